counter_x_multi: RTL and testbench

Parametrised successor to the 3-channel bus counter in the MIO peripheral set. It provides CH_NUM independent down-counters of CNT_W bits, each clocked by its own tick source (typically clkdiv bits). Each channel has a programmable mode: one-shot, auto-reload or square-wave. It adds per-channel status flags, a readable live count, and a combined interrupt line. It sits on the MIO bus as the counter peripheral and is written through the Peripheral_in/counter_we path.

---
 rtl/counter_x_multi_if.sv | 18 +
 rtl/counter_x_multi.sv | 158 +++++++++++++++
 tb/tb_counter_x_multi.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/counter_x_multi_if.sv
`default_nettype none
// ============================================================================
// Module  : counter_x_multi_if
// Brief   : Register bus between the MIO host and the counter peripheral.
// Revision: 1.0
// ============================================================================
interface counter_x_multi_if;
    logic        we;
    logic [2:0]  sel;
    logic [1:0]  reg_sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output we, sel, reg_sel, wdata, input rdata, irq);
    modport slave  (input we, sel, reg_sel, wdata, output rdata, irq);
endinterface
`default_nettype wire

// File: rtl/counter_x_multi.sv
`default_nettype none
// ============================================================================
// Module  : counter_x_multi
// Brief   : CH_NUM tick-driven down-counters (one-shot / auto-reload / square)
// Revision: 1.0
// ============================================================================
module counter_x_multi #(
    parameter int CH_NUM = 4,
    parameter int CNT_W  = 32
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic [CH_NUM-1:0] tick_i,
    output logic      [CH_NUM-1:0] cnt_out_o,
    counter_x_multi_if.slave       bus_if
);
    localparam logic [1:0]       C_REG_LOAD   = 2'b00;
    localparam logic [1:0]       C_REG_CTRL   = 2'b01;
    localparam logic [1:0]       C_REG_STATUS = 2'b10;
    localparam logic [1:0]       C_REG_COUNT  = 2'b11;
    localparam logic [1:0]       C_MODE_AUTO  = 2'b01;
    localparam logic [1:0]       C_MODE_SQR   = 2'b10;
    localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);

    logic [CH_NUM-1:0] tick_s1_q, tick_s2_q, tick_s3_q;
    logic [CH_NUM-1:0] event_w;
    logic              sel_ok_w;
    logic              wr_ok_w;
    logic              irq_q;

    logic [CH_NUM-1:0][CNT_W-1:0] load_w;
    logic [CH_NUM-1:0][CNT_W-1:0] count_w;
    logic [CH_NUM-1:0][3:0]       ctrl_w;
    logic [CH_NUM-1:0]            status_w;
    logic [CH_NUM-1:0]            irq_en_w;
    logic [31:0]                  rdata_w;

    // s1/s2 resynchronise the async tick; s3 only serves edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_s1_q <= '0;
            tick_s2_q <= '0;
            tick_s3_q <= '0;
        end else begin
            tick_s1_q <= tick_i;
            tick_s2_q <= tick_s1_q;
            tick_s3_q <= tick_s2_q;
        end
    end

    assign event_w  = tick_s2_q & ~tick_s3_q;
    assign sel_ok_w = ({1'b0, bus_if.sel} < 4'(CH_NUM));
    assign wr_ok_w  = bus_if.we & sel_ok_w;

    generate
        for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
            logic [CNT_W-1:0] count_q, count_d, load_q, load_d;
            logic [3:0]       ctrl_q, ctrl_d;
            logic             status_q, status_d, out_q, out_d;
            logic             wr_ch_w;

            assign wr_ch_w = wr_ok_w && (bus_if.sel == 3'(g));

            always_comb begin
                count_d  = count_q;
                load_d   = load_q;
                ctrl_d   = ctrl_q;
                status_d = status_q;
                out_d    = out_q;
                if (ctrl_q[2:1] == C_MODE_AUTO) begin
                    out_d = 1'b0;
                end
                // Clear first so a coincident terminal event re-sets the flag
                if (wr_ch_w && bus_if.reg_sel == C_REG_STATUS && bus_if.wdata[0]) begin
                    status_d = 1'b0;
                end
                if (wr_ch_w && bus_if.reg_sel == C_REG_LOAD) begin
                    load_d  = bus_if.wdata[CNT_W-1:0];
                    count_d = bus_if.wdata[CNT_W-1:0];
                    out_d   = 1'b0;
                end else if (wr_ch_w && bus_if.reg_sel == C_REG_CTRL) begin
                    ctrl_d = bus_if.wdata[3:0];
                end else if (event_w[g] && ctrl_q[0]) begin
                    if (count_q > C_ONE) begin
                        count_d = count_q - C_ONE;
                    end else if (count_q == C_ONE) begin
                        status_d = 1'b1;
                        case (ctrl_q[2:1])
                            C_MODE_AUTO: begin
                                count_d = load_q;
                                out_d   = 1'b1;
                            end
                            C_MODE_SQR: begin
                                count_d = load_q;
                                out_d   = ~out_q;
                            end
                            default: begin
                                count_d   = '0;
                                out_d     = 1'b1;
                                ctrl_d[0] = 1'b0;
                            end
                        endcase
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_q  <= '0;
                    load_q   <= '0;
                    ctrl_q   <= '0;
                    status_q <= 1'b0;
                    out_q    <= 1'b0;
                end else begin
                    count_q  <= count_d;
                    load_q   <= load_d;
                    ctrl_q   <= ctrl_d;
                    status_q <= status_d;
                    out_q    <= out_d;
                end
            end

            assign load_w[g]    = load_q;
            assign count_w[g]   = count_q;
            assign ctrl_w[g]    = ctrl_q;
            assign status_w[g]  = status_q;
            assign irq_en_w[g]  = ctrl_q[3];
            assign cnt_out_o[g] = out_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(status_w & irq_en_w);
        end
    end

    always_comb begin
        rdata_w = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (sel_ok_w && bus_if.sel == k[2:0]) begin
                case (bus_if.reg_sel)
                    C_REG_LOAD:   rdata_w = 32'(load_w[k]);
                    C_REG_CTRL:   rdata_w = {28'd0, ctrl_w[k]};
                    C_REG_STATUS: rdata_w = {31'd0, status_w[k]};
                    C_REG_COUNT:  rdata_w = 32'(count_w[k]);
                    default:      rdata_w = '0;
                endcase
            end
        end
    end

    assign bus_if.rdata = rdata_w;
    assign bus_if.irq   = irq_q;
endmodule
`default_nettype wire

// File: tb/tb_counter_x_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_counter_x_multi
// Brief   : Directed self-checking bench for counter_x_multi (32-bit and 8-bit builds).
// Revision: 1.0
// ============================================================================
module tb_counter_x_multi;
    localparam logic [1:0] C_LOAD   = 2'b00;
    localparam logic [1:0] C_CTRL   = 2'b01;
    localparam logic [1:0] C_STATUS = 2'b10;
    localparam logic [1:0] C_COUNT  = 2'b11;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] tick  = '0;
    logic [3:0] cnt_out;
    logic [1:0] tick8 = '0;
    logic [1:0] cnt_out8;
    int         total = 0;
    int         bad   = 0;
    int         pulses1 = 0;
    logic [31:0] v;

    always #5 clk = ~clk;

    counter_x_multi_if bus ();
    counter_x_multi_if bus8 ();

    counter_x_multi #(.CH_NUM(4), .CNT_W(32)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_i    (tick),
        .cnt_out_o (cnt_out),
        .bus_if    (bus)
    );

    counter_x_multi #(.CH_NUM(2), .CNT_W(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_i    (tick8),
        .cnt_out_o (cnt_out8),
        .bus_if    (bus8)
    );

    always @(negedge clk) if (cnt_out[1] === 1'b1) pulses1++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input bit b8, input logic [2:0] s, input logic [1:0] r, input logic [31:0] d);
        @(negedge clk);
        if (b8) begin
            bus8.we = 1'b1; bus8.sel = s; bus8.reg_sel = r; bus8.wdata = d;
        end else begin
            bus.we = 1'b1; bus.sel = s; bus.reg_sel = r; bus.wdata = d;
        end
        @(negedge clk);
        bus.we  = 1'b0;
        bus8.we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input bit b8, input logic [2:0] s,
                          input logic [1:0] r, input logic [31:0] exp);
        if (b8) begin
            bus8.sel = s; bus8.reg_sel = r;
        end else begin
            bus.sel = s; bus.reg_sel = r;
        end
        #1;
        chk(tag, b8 ? bus8.rdata : bus.rdata, exp);
    endtask

    task automatic tick_rise(input int ch);
        tick[ch] = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic tick_fall(input int ch);
        tick[ch] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Drive a bus write so it lands on the same clk edge as the tick event
    task automatic wr_on_event(input int ch, input logic [1:0] r, input logic [31:0] d);
        tick[ch] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.we = 1'b1; bus.sel = 3'(ch); bus.reg_sel = r; bus.wdata = d;
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    initial begin
        bus.we = 1'b0; bus.sel = '0; bus.reg_sel = '0; bus.wdata = '0;
        bus8.we = 1'b0; bus8.sel = '0; bus8.reg_sel = '0; bus8.wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while channel 3 is mid-count
        wr(0, 3, C_LOAD, 32'd7);
        wr(0, 3, C_CTRL, 32'h1);
        tick_rise(3); tick_fall(3); tick_rise(3);
        rd_chk("pre_rst_count", 0, 3, C_COUNT, 32'd5);
        #2 rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick = 4'($urandom);
            @(negedge clk);
        end
        tick = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_cnt_out", {28'd0, cnt_out}, 32'd0);
        chk("rst_irq", {31'd0, bus.irq}, 32'd0);
        rd_chk("rst_load", 0, 3, C_LOAD, 32'd0);
        rd_chk("rst_ctrl", 0, 3, C_CTRL, 32'd0);
        rd_chk("rst_status", 0, 3, C_STATUS, 32'd0);
        rd_chk("rst_count", 0, 3, C_COUNT, 32'd0);
        tick_rise(3);
        rd_chk("rst_no_move", 0, 3, C_COUNT, 32'd0);
        tick_fall(3);

        // One-shot on ch0
        wr(0, 0, C_LOAD, 32'd5);
        wr(0, 0, C_CTRL, 32'h9);
        for (int i = 1; i <= 5; i++) begin
            tick_rise(0);
            rd_chk("os_count", 0, 0, C_COUNT, 32'(5 - i));
            if (i == 5) begin
                chk("os_irq_lag", {31'd0, bus.irq}, 32'd0);
                @(negedge clk);
                chk("os_irq", {31'd0, bus.irq}, 32'd1);
            end
            tick_fall(0);
        end
        chk("os_out", {31'd0, cnt_out[0]}, 32'd1);
        rd_chk("os_status", 0, 0, C_STATUS, 32'd1);
        rd_chk("os_ctrl_en_clr", 0, 0, C_CTRL, 32'h8);
        tick_rise(0); tick_fall(0);
        rd_chk("os_6th", 0, 0, C_COUNT, 32'd0);
        chk("os_out_held", {31'd0, cnt_out[0]}, 32'd1);
        wr(0, 0, C_STATUS, 32'd1);
        chk("os_irq_fall_lag", {31'd0, bus.irq}, 32'd1);
        @(negedge clk);
        chk("os_irq_fall", {31'd0, bus.irq}, 32'd0);

        // Auto-reload on ch1
        wr(0, 1, C_LOAD, 32'd3);
        wr(0, 1, C_CTRL, 32'h3);
        for (int i = 1; i <= 9; i++) begin
            tick_rise(1);
            rd_chk("ar_count", 0, 1, C_COUNT, (i % 3 == 0) ? 32'd3 : 32'(3 - i % 3));
            chk("ar_out", {31'd0, cnt_out[1]}, (i % 3 == 0) ? 32'd1 : 32'd0);
            if (i % 3 == 0) begin
                @(negedge clk);
                chk("ar_out_1clk", {31'd0, cnt_out[1]}, 32'd0);
            end
            tick_fall(1);
        end
        chk("ar_pulses", 32'(pulses1), 32'd3);

        // Square-wave on ch2
        wr(0, 2, C_LOAD, 32'd4);
        wr(0, 2, C_CTRL, 32'h5);
        for (int i = 1; i <= 16; i++) begin
            tick_rise(2);
            chk("sq_out", {31'd0, cnt_out[2]}, 32'((i / 4) % 2));
            tick_fall(2);
        end
        chk("sq_irq", {31'd0, bus.irq}, 32'd0);

        // Collisions on ch0
        wr(0, 0, C_LOAD, 32'd20);
        wr(0, 0, C_CTRL, 32'h1);
        wr_on_event(0, C_LOAD, 32'd10);
        rd_chk("col_load", 0, 0, C_COUNT, 32'd10);
        tick_fall(0);
        tick_rise(0);
        rd_chk("col_after", 0, 0, C_COUNT, 32'd9);
        tick_fall(0);
        wr(0, 0, C_LOAD, 32'd1);
        wr_on_event(0, C_STATUS, 32'd1);
        rd_chk("col_status", 0, 0, C_STATUS, 32'd1);
        rd_chk("col_term_cnt", 0, 0, C_COUNT, 32'd0);
        tick_fall(0);

        // Out-of-range channel and parked channel
        wr(0, 4, C_LOAD, 32'h55);
        wr(0, 4, C_CTRL, 32'hF);
        rd_chk("oor_load", 0, 4, C_LOAD, 32'd0);
        rd_chk("oor_ctrl", 0, 4, C_CTRL, 32'd0);
        rd_chk("oor_ch0_load", 0, 0, C_LOAD, 32'd1);
        rd_chk("oor_ch0_ctrl", 0, 0, C_CTRL, 32'd0);
        wr(0, 3, C_LOAD, 32'd0);
        wr(0, 3, C_CTRL, 32'h9);
        for (int i = 0; i < 10; i++) begin
            tick_rise(3); tick_fall(3);
        end
        rd_chk("park_status", 0, 3, C_STATUS, 32'd0);
        rd_chk("park_count", 0, 3, C_COUNT, 32'd0);
        chk("park_out", {31'd0, cnt_out[3]}, 32'd0);
        chk("park_irq", {31'd0, bus.irq}, 32'd0);

        // 8-bit, 2-channel build
        wr(1, 1, C_LOAD, 32'h1FF);
        rd_chk("w8_count", 1, 1, C_COUNT, 32'hFF);
        rd_chk("w8_load", 1, 1, C_LOAD, 32'hFF);
        wr(1, 1, C_CTRL, 32'h1);
        tick8[1] = 1'b1;
        repeat (3) @(negedge clk);
        rd_chk("w8_dec", 1, 1, C_COUNT, 32'hFE);
        tick8[1] = 1'b0;
        repeat (3) @(negedge clk);
        wr(1, 2, C_LOAD, 32'h12);
        rd_chk("w8_oor", 1, 2, C_LOAD, 32'd0);
        rd_chk("w8_ch0", 1, 0, C_LOAD, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
